mgmt_bus_arb: RTL and testbench
===============================

// Module: mgmt_bus_arb
// PURPOSE
// - Shares one sys_bus slave port (management/config register block) between NR requesters.
// - Requesters are, e.g., the PS AXI bridge and an on-chip boot/config sequencer.
// - Latches each requester's single-cycle wen/ren pulse and grants round-robin.
// - Forwards one transaction at a time; routes ack/err/rdata back to the owner.
// PARAMETERS
// NR   2    number of requesters (2..8)
// AW   32   address width
// DW   32   data width
// TMO  255  slave response timeout in cycles (used only with MGMT_ARB_TIMEOUT_EN)
// PORTS
// clk        in   1        clock
// rst        in   1        synchronous reset, active high
// req_wen    in   NR       per-requester write pulse (1 cycle)
// req_ren    in   NR       per-requester read pulse (1 cycle)
// req_addr   in   NR*AW    per-requester address, sampled with pulse
// req_wdata  in   NR*DW    per-requester write data, sampled with pulse
// req_rdata  out  DW       read data, valid with req_ack of owner
// req_ack    out  NR       per-requester completion pulse
// req_err    out  NR       per-requester error pulse
// s_wen      out  1        slave write pulse
// s_ren      out  1        slave read pulse
// s_addr     out  AW       slave address
// s_wdata    out  DW       slave write data
// s_rdata    in   DW       slave read data, valid with s_ack
// s_ack      in   1        slave completion
// s_err      in   1        slave error
// BEHAVIOUR
// - Reset: all outputs 0, all pending flags 0, state IDLE, rr pointer NR-1 (req 0 wins first).
// - Capture: req_wen|req_ren on requester i with pend[i]=0 sets pend[i] and latches op/addr/wdata.
//   - Pulse while pend[i]=1 is ignored; requester protocol forbids it.
//   - A pulse in the same cycle as req_ack/req_err to i is accepted.
// - wen & ren both high on one requester: latched as ILLEGAL, never forwarded.
//   - Answered with req_err one cycle after grant.
// - FSM IDLE -> ISSUE -> WAIT -> IDLE:
//   - IDLE: if any pend, grant first pending index after rr pointer (wrapping); rr <= grant; -> ISSUE.
//   - ISSUE: one cycle; s_wen or s_ren = 1 with latched addr/wdata; -> WAIT.
//   - WAIT: s_ack|s_err seen -> next cycle req_ack/req_err[grant] = 1.
//     - req_rdata = s_rdata; pend[grant] cleared; -> IDLE.
// - s_addr/s_wdata hold last issued values outside ISSUE.
// - req_rdata holds its last value between acks.
// - s_ack and s_err together: both forwarded.
// - s_ack/s_err outside WAIT: discarded.
// - Uncontended latency: request pulse cycle 0, s_wen/s_ren cycle 2, slave acks cycle 3, req_ack cycle 4.
// - Back-to-back: after a completion, the next grant may be taken in the same IDLE cycle.
// - Fairness: with all NR pending, each requester is served once per NR transactions.
// - rst mid-transaction: everything returns to reset values.
//   - The in-flight slave response is dropped; no req_ack.
// CONFIGURATION
// MGMT_ARB_TIMEOUT_EN
// - Defined: WAIT counts cycles.
//   - After TMO cycles with no s_ack/s_err, req_err[grant] pulses and FSM -> IDLE.
//   - A late slave ack is discarded.
//   - s_ack in the same cycle as expiry wins (normal completion).
// - Not defined: WAIT waits indefinitely; no counter logic.
// TESTING
// - Single write, req 0, addr 'h04, data 'h3:
//   - s_wen cycle 2 with addr 'h04 / data 'h3; req_ack[0] cycle 4; req_err=0.
// - Read, req 1, addr 'h00, slave returns 'hA5:
//   - req_ack[1] with req_rdata='hA5; req_ack[0] stays 0.
// - Both requesters pulse in cycle 0:
//   - req 0 issued first, then req 1; then pulse both again: req 0 first again (rr).
//   - Repeat 100 times: each served 100 times.
// - req 0 pulses wen and ren together: no s_wen/s_ren; req_err[0] cycle 3.
// - Timeout (macro defined, TMO=8), slave never acks:
//   - req_err[0] 8 cycles into WAIT; late s_ack ignored; next request completes normally.
// - rst pulsed during WAIT: all outputs 0 next cycle; subsequent s_ack gives no req_ack.

Source files
------------

// File: rtl/mgmt_bus_arb_if.sv
// mgmt_bus_arb_if: sys_bus style register-access bundle, N lanes wide.
//
// The same interface describes both sides of the arbiter:
//   - requester side: N = NR lanes, one lane per requester
//   - slave side:     N = 1, the single shared register block port
//
// Signals (per lane unless noted):
//   wen, ren   write / read pulse, one cycle
//   addr       address, valid with the pulse (lane i at [i*AW +: AW])
//   wdata      write data, valid with the pulse (lane i at [i*DW +: DW])
//   rdata      read data, valid with ack (shared by all lanes)
//   ack, err   completion / error pulse
//
// Modports:
//   master     issues accesses (drives wen/ren/addr/wdata)
//   slave      answers accesses (drives rdata/ack/err)

interface mgmt_bus_arb_if #(
    parameter int unsigned N  = 1,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [N-1:0]    wen;
    logic [N-1:0]    ren;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata;
    logic [N-1:0]    ack;
    logic [N-1:0]    err;

    modport master (
        output wen, ren, addr, wdata,
        input  rdata, ack, err
    );

    modport slave (
        input  wen, ren, addr, wdata,
        output rdata, ack, err
    );
endinterface

// File: rtl/mgmt_bus_arb.sv
// mgmt_bus_arb: shares one sys_bus slave port (management/config register block)
// between NR requesters, e.g. the PS AXI bridge and a boot/config sequencer.
//
// Each requester's single-cycle wen/ren pulse is latched into a pending slot;
// pending slots are granted round-robin and forwarded one at a time. The slave's
// ack/err/rdata are routed back to the owner of the in-flight transaction.
// A pulse with both wen and ren set is never forwarded and is answered with err.
//
// Ports:
//   clk    clock
//   rst    synchronous reset, active high
//   req    requester side (slave modport, NR lanes)
//   s      shared slave port (master modport, one lane)
//
// Build option:
//   MGMT_ARB_TIMEOUT_EN  when defined, a slave silent for TMO cycles in WAIT is
//                        answered with err to the owner; a late ack is dropped.

module mgmt_bus_arb #(
    parameter int unsigned NR  = 2,
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned TMO = 255
) (
    input logic           clk,
    input logic           rst,
    mgmt_bus_arb_if.slave  req,
    mgmt_bus_arb_if.master s
);
    localparam int unsigned IW = (NR > 1) ? $clog2(NR) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [NR-1:0]   ack_q, ack_d;
    logic [NR-1:0]   err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [AW-1:0]   saddr_q, saddr_d;
    logic [DW-1:0]   swdata_q, swdata_d;

    // Per-requester latched request
    logic [NR-1:0]   pend_q;
    logic [NR-1:0]   wr_q;
    logic [NR-1:0]   ill_q;
    logic [AW-1:0]   addr_q  [NR];
    logic [DW-1:0]   wdata_q [NR];
    logic [NR-1:0]   clr;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            expire;

`ifdef MGMT_ARB_TIMEOUT_EN
    localparam int unsigned TW = (TMO > 1) ? $clog2(TMO + 1) : 1;
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d  = '0;
        expire = 1'b0;
        if (state_q == StWait) begin
            tmo_d  = tmo_q + 1'b1;
            expire = (tmo_q == TW'(TMO - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO;
    assign expire     = 1'b0;
`endif

    // First pending requester after the rr pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= int'(NR); k++) begin
            cand = IW'((int'(rr_q) + k) % int'(NR));
            if (!found && pend_q[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        ack_d    = '0;
        err_d    = '0;
        rdata_d  = rdata_q;
        saddr_d  = saddr_q;
        swdata_d = swdata_q;
        clr      = '0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = pick;
                    rr_d    = pick;
                    state_d = StIssue;
                    // Illegal requests are never issued, so the bus keeps its old values.
                    if (!ill_q[pick]) begin
                        saddr_d  = addr_q[pick];
                        swdata_d = wdata_q[pick];
                    end
                end
            end
            StIssue: begin
                if (ill_q[grant_q]) begin
                    err_d[grant_q] = 1'b1;
                    clr[grant_q]   = 1'b1;
                    state_d        = StIdle;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // A slave response in the expiry cycle takes priority over the timeout.
                if (s.ack[0] || s.err[0]) begin
                    ack_d[grant_q] = s.ack[0];
                    err_d[grant_q] = s.err[0];
                    rdata_d        = s.rdata;
                    clr[grant_q]   = 1'b1;
                    state_d        = StIdle;
                end else if (expire) begin
                    err_d[grant_q] = 1'b1;
                    clr[grant_q]   = 1'b1;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_q     <= IW'(NR - 1);
            ack_q    <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            saddr_q  <= '0;
            swdata_q <= '0;
            pend_q   <= '0;
            wr_q     <= '0;
            ill_q    <= '0;
            for (int i = 0; i < int'(NR); i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            saddr_q  <= saddr_d;
            swdata_q <= swdata_d;
            // clr only hits a pending slot, so it never collides with a capture.
            for (int i = 0; i < int'(NR); i++) begin
                if (clr[i]) begin
                    pend_q[i] <= 1'b0;
                end else if (!pend_q[i] && (req.wen[i] || req.ren[i])) begin
                    pend_q[i]  <= 1'b1;
                    wr_q[i]    <= req.wen[i];
                    ill_q[i]   <= req.wen[i] && req.ren[i];
                    addr_q[i]  <= req.addr[i*AW +: AW];
                    wdata_q[i] <= req.wdata[i*DW +: DW];
                end
            end
        end
    end

    assign s.wen[0]  = (state_q == StIssue) && !ill_q[grant_q] && wr_q[grant_q];
    assign s.ren[0]  = (state_q == StIssue) && !ill_q[grant_q] && !wr_q[grant_q];
    assign s.addr    = saddr_q;
    assign s.wdata   = swdata_q;
    assign req.ack   = ack_q;
    assign req.err   = err_q;
    assign req.rdata = rdata_q;
endmodule

// File: tb/tb_mgmt_bus_arb.sv
// tb_mgmt_bus_arb: directed self-checking bench for mgmt_bus_arb (NR = 2).
// Cycle numbers in comments count from the cycle in which a request pulse is driven.
// The timeout scenario runs only when MGMT_ARB_TIMEOUT_EN is defined (TMO = 8).

module tb_mgmt_bus_arb;
    localparam int unsigned NR  = 2;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mgmt_bus_arb_if #(.N(NR), .AW(AW), .DW(DW)) rq ();
    mgmt_bus_arb_if #(.N(1),  .AW(AW), .DW(DW)) sb ();

    mgmt_bus_arb #(
        .NR  (NR),
        .AW  (AW),
        .DW  (DW),
        .TMO (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .req (rq),
        .s   (sb)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rq.wen = '0; rq.ren = '0; rq.addr = '0; rq.wdata = '0;
        sb.ack = '0; sb.err = '0; sb.rdata = '0;
        step();
        step();
        checks++;
        if (rq.ack !== 2'b00) begin
            errors++; $display("FAIL reset_ack: got %b want 00", rq.ack);
        end
        checks++;
        if (rq.err !== 2'b00) begin
            errors++; $display("FAIL reset_err: got %b want 00", rq.err);
        end
        checks++;
        if (rq.rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want 0", rq.rdata);
        end
        checks++;
        if ({sb.wen, sb.ren} !== 2'b00) begin
            errors++; $display("FAIL reset_s_wen_ren: got %b want 00", {sb.wen, sb.ren});
        end
        checks++;
        if (sb.addr !== 32'h0 || sb.wdata !== 32'h0) begin
            errors++; $display("FAIL reset_s_addr_wdata: got %h/%h want 0/0", sb.addr, sb.wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        rq.wen = 2'b01; rq.addr = {32'h0, 32'h04}; rq.wdata = {32'h0, 32'h3};  // cycle 0
        step();                                                                // cycle 1
        rq.wen = 2'b00;
        checks++;
        if (sb.wen !== 1'b0) begin
            errors++; $display("FAIL wr_early_swen: got %b want 0 at cycle 1", sb.wen);
        end
        step();                                                                // cycle 2
        checks++;
        if (sb.wen !== 1'b1 || sb.ren !== 1'b0) begin
            errors++; $display("FAIL wr_swen: got wen %b ren %b want 1/0", sb.wen, sb.ren);
        end
        checks++;
        if (sb.addr !== 32'h04 || sb.wdata !== 32'h3) begin
            errors++; $display("FAIL wr_s_addr_data: got %h/%h want 4/3", sb.addr, sb.wdata);
        end
        step();                                                                // cycle 3
        checks++;
        if (sb.wen !== 1'b0 || rq.ack !== 2'b00) begin
            errors++; $display("FAIL wr_cycle3: got swen %b ack %b want 0/00", sb.wen, rq.ack);
        end
        sb.ack = 1'b1;
        step();                                                                // cycle 4
        sb.ack = 1'b0;
        checks++;
        if (rq.ack !== 2'b01 || rq.err !== 2'b00) begin
            errors++; $display("FAIL wr_ack: got ack %b err %b want 01/00", rq.ack, rq.err);
        end
        step();                                                                // cycle 5
        checks++;
        if (rq.ack !== 2'b00) begin
            errors++; $display("FAIL wr_ack_pulse: got %b want 00", rq.ack);
        end
    endtask

    task automatic test_read();
        rq.ren = 2'b10; rq.addr = {32'h0, 32'h0};                              // cycle 0
        step();
        rq.ren = 2'b00;
        step();                                                                // cycle 2
        checks++;
        if (sb.ren !== 1'b1 || sb.wen !== 1'b0 || sb.addr !== 32'h0) begin
            errors++; $display("FAIL rd_issue: got ren %b wen %b addr %h want 1/0/0",
                               sb.ren, sb.wen, sb.addr);
        end
        step();                                                                // cycle 3
        sb.ack = 1'b1; sb.rdata = 32'hA5;
        step();                                                                // cycle 4
        sb.ack = 1'b0; sb.rdata = 32'h0;
        checks++;
        if (rq.ack !== 2'b10) begin
            errors++; $display("FAIL rd_ack: got %b want 10", rq.ack);
        end
        checks++;
        if (rq.rdata !== 32'hA5) begin
            errors++; $display("FAIL rd_rdata: got %h want a5", rq.rdata);
        end
        step();
        checks++;
        if (rq.rdata !== 32'hA5) begin
            errors++; $display("FAIL rd_rdata_hold: got %h want a5", rq.rdata);
        end
    endtask

    task automatic test_round_robin();
        int cnt0 = 0;
        int cnt1 = 0;
        for (int it = 0; it < 100; it++) begin
            int  seen = 0;
            int  got  = 0;
            logic ack_next = 1'b0;
            rq.wen = 2'b11; rq.addr = {32'h20, 32'h10}; rq.wdata = {32'h2, 32'h1};
            step();
            rq.wen = 2'b00;
            for (int c = 0; c < 12 && got < 2; c++) begin
                sb.ack   = ack_next;
                ack_next = 1'b0;
                if (sb.wen === 1'b1) begin
                    checks++;
                    if (sb.addr !== ((seen == 0) ? 32'h10 : 32'h20)) begin
                        errors++; $display("FAIL rr_order: iter %0d issue %0d got addr %h want %h",
                                           it, seen, sb.addr, (seen == 0) ? 32'h10 : 32'h20);
                    end
                    seen++;
                    ack_next = 1'b1;
                end
                if (rq.ack[0] === 1'b1) begin cnt0++; got++; end
                if (rq.ack[1] === 1'b1) begin cnt1++; got++; end
                if (got < 2) step();
            end
            sb.ack = 1'b0;
            checks++;
            if (got != 2) begin
                errors++; $display("FAIL rr_complete: iter %0d got %0d acks want 2", it, got);
            end
        end
        checks++;
        if (cnt0 != 100 || cnt1 != 100) begin
            errors++; $display("FAIL rr_fairness: got %0d/%0d want 100/100", cnt0, cnt1);
        end
    endtask

    task automatic test_illegal();
        step();
        rq.wen = 2'b01; rq.ren = 2'b01; rq.addr = {32'h0, 32'hFF};           // cycle 0
        step();                                                                // cycle 1
        rq.wen = 2'b00; rq.ren = 2'b00;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({sb.wen, sb.ren} !== 2'b00) begin
                errors++; $display("FAIL ill_forwarded: cycle %0d got %b want 00", c, {sb.wen, sb.ren});
            end
            checks++;
            if (rq.err !== ((c == 3) ? 2'b01 : 2'b00) || rq.ack !== 2'b00) begin
                errors++; $display("FAIL ill_err: cycle %0d got err %b ack %b want %b/00",
                                   c, rq.err, rq.ack, (c == 3) ? 2'b01 : 2'b00);
            end
            if (c == 3) begin
                checks++;
                if (sb.addr !== 32'h20) begin
                    errors++; $display("FAIL ill_addr_hold: got %h want 20", sb.addr);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        rq.wen = 2'b01; rq.addr = {32'h0, 32'h40}; rq.wdata = {32'h0, 32'h1};  // cycle 0
        step();
        rq.wen = 2'b00;
        step();
        step();                                                                // cycle 3
        sb.ack = 1'b1;
        step();                                                                // cycle 4
        sb.ack = 1'b0;
        checks++;
        if (rq.ack !== 2'b01) begin
            errors++; $display("FAIL b2b_first_ack: got %b want 01", rq.ack);
        end
        rq.wen = 2'b01; rq.addr = {32'h0, 32'h44}; rq.wdata = {32'h0, 32'h2};  // new pulse with ack
        step();                                                                // cycle 5
        rq.wen = 2'b00;
        step();                                                                // cycle 6
        checks++;
        if (sb.wen !== 1'b1 || sb.addr !== 32'h44 || sb.wdata !== 32'h2) begin
            errors++; $display("FAIL b2b_second_issue: got wen %b addr %h data %h want 1/44/2",
                               sb.wen, sb.addr, sb.wdata);
        end
        step();                                                                // cycle 7
        sb.ack = 1'b1; sb.err = 1'b1; sb.rdata = 32'h5A;
        step();                                                                // cycle 8
        sb.ack = 1'b0; sb.err = 1'b0; sb.rdata = 32'h0;
        checks++;
        if (rq.ack !== 2'b01 || rq.err !== 2'b01) begin
            errors++; $display("FAIL b2b_ack_err: got ack %b err %b want 01/01", rq.ack, rq.err);
        end
        checks++;
        if (rq.rdata !== 32'h5A) begin
            errors++; $display("FAIL b2b_rdata: got %h want 5a", rq.rdata);
        end
    endtask

`ifdef MGMT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        step();
        rq.wen = 2'b01; rq.addr = {32'h0, 32'h08}; rq.wdata = {32'h0, 32'h9};  // cycle 0
        step();
        rq.wen = 2'b00;
        for (int c = 1; c <= 10; c++) step();                                  // cycle 11
        checks++;
        if (rq.err !== 2'b01 || rq.ack !== 2'b00) begin
            errors++; $display("FAIL tmo_err: got err %b ack %b want 01/00", rq.err, rq.ack);
        end
        sb.ack = 1'b1;                                                         // late ack
        step();
        sb.ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rq.ack !== 2'b00 || rq.err !== 2'b00) begin
                errors++; $display("FAIL tmo_late_ack: got ack %b err %b want 00/00", rq.ack, rq.err);
            end
            step();
        end
        rq.ren = 2'b10; rq.addr = {32'h0C, 32'h0};                              // cycle 0
        step();
        rq.ren = 2'b00;
        step();
        step();                                                                // cycle 3
        sb.ack = 1'b1; sb.rdata = 32'h66;
        step();                                                                // cycle 4
        sb.ack = 1'b0; sb.rdata = 32'h0;
        checks++;
        if (rq.ack !== 2'b10 || rq.rdata !== 32'h66) begin
            errors++; $display("FAIL tmo_recover: got ack %b rdata %h want 10/66", rq.ack, rq.rdata);
        end
    endtask
`endif

    task automatic test_reset_mid();
        step();
        rq.ren = 2'b01; rq.addr = {32'h0, 32'h30};                              // cycle 0
        step();
        rq.ren = 2'b00;
        step();                                                                // cycle 2
        checks++;
        if (sb.ren !== 1'b1 || sb.addr !== 32'h30) begin
            errors++; $display("FAIL rst_mid_issue: got ren %b addr %h want 1/30", sb.ren, sb.addr);
        end
        step();                                                                // cycle 3, WAIT
        rst = 1'b1;
        step();                                                                // cycle 4
        rst = 1'b0;
        checks++;
        if (rq.ack !== 2'b00 || rq.err !== 2'b00 || rq.rdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid_req_out: got ack %b err %b rdata %h want 00/00/0",
                               rq.ack, rq.err, rq.rdata);
        end
        checks++;
        if ({sb.wen, sb.ren} !== 2'b00 || sb.addr !== 32'h0 || sb.wdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid_s_out: got wen/ren %b addr %h data %h want 00/0/0",
                               {sb.wen, sb.ren}, sb.addr, sb.wdata);
        end
        sb.ack = 1'b1; sb.rdata = 32'h99;
        step();
        sb.ack = 1'b0; sb.rdata = 32'h0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rq.ack !== 2'b00 || rq.rdata !== 32'h0) begin
                errors++; $display("FAIL rst_mid_dropped: got ack %b rdata %h want 00/0", rq.ack, rq.rdata);
            end
            step();
        end
        // rr pointer is back to NR-1, so requester 0 wins a tie
        rq.wen = 2'b11; rq.addr = {32'h24, 32'h14}; rq.wdata = {32'h0, 32'h0};
        step();
        rq.wen = 2'b00;
        step();                                                                // cycle 2
        checks++;
        if (sb.wen !== 1'b1 || sb.addr !== 32'h14) begin
            errors++; $display("FAIL rst_mid_rr: got wen %b addr %h want 1/14", sb.wen, sb.addr);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_round_robin();
        test_illegal();
        test_back_to_back();
`ifdef MGMT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
